// File: rtl/int_pkg.sv
// Shared state encoding and constants for the interrupt arbiter.
package int_pkg;

    localparam int unsigned MAX_NUM_SRC        = 16;
    localparam int unsigned DEF_EXT_CAUSE_BASE = 16;
    localparam logic [31:0] SYSCALL_CAUSE      = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder: index of the lowest set request bit plus a valid flag.
module prio_enc
    import int_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned IDX_W = idx_width(W)
) (
    input  logic [W-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// Exception/interrupt arbiter feeding the control FSM (syscall plus NUM_SRC masked sources).
// Define INT_EDGE_EN for edge-captured pending bits; default build passes irq through as level.
module int_arbiter
    import int_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 8,
    parameter int unsigned EXT_CAUSE_BASE = DEF_EXT_CAUSE_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               syscall,
    input  logic               eret,
    input  logic               int_ack,
    output logic               int_req,
    output logic [31:0]        int_cause,
    output logic               int_enable,
    output logic [NUM_SRC-1:0] int_mask,
    output logic [NUM_SRC-1:0] int_pending
);

    localparam int unsigned IDX_W = idx_width(NUM_SRC);

    state_e             state_q, state_d;
    logic               ie_q, ie_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [31:0]        cause_q, cause_d;
    logic [NUM_SRC-1:0] pending;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               take_sys, take_ext, ack_fire, eret_fire;

    prio_enc #(.W(NUM_SRC), .IDX_W(IDX_W)) u_prio_enc (
        .req_i   (pending & mask_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Syscall bypasses the global enable; external sources need it.
    assign take_sys  = (state_q == ST_IDLE) && syscall;
    assign take_ext  = (state_q == ST_IDLE) && !syscall && ie_q && win_valid;
    assign ack_fire  = (state_q == ST_REQ) && int_ack;
    assign eret_fire = (state_q == ST_SERVICE) && eret;

    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        cause_d = cause_q;
        mask_d  = mask_we ? mask_wdata : mask_q;
        if (take_sys) begin
            state_d = ST_REQ;
            cause_d = SYSCALL_CAUSE;
        end else if (take_ext) begin
            state_d = ST_REQ;
            cause_d = 32'(EXT_CAUSE_BASE) + 32'(win_idx);
        end else if (ack_fire) begin
            state_d = ST_SERVICE;
            ie_d    = 1'b0;
        end else if (eret_fire) begin
            state_d = ST_IDLE;
            ie_d    = 1'b1;
        end
    end

    // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking assignment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ie_q    <= 1'b1;
            mask_q  <= '1;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            mask_q  <= mask_d;
            cause_q <= cause_d;
        end
    end

`ifdef INT_EDGE_EN
    logic [NUM_SRC-1:0] irq_prev_q, pend_q, pend_d, clr;
    logic [IDX_W-1:0]   srv_idx_q, srv_idx_d;
    logic               srv_ext_q, srv_ext_d;

    // Remember which source was granted so the ack clears only that bit; a new rise wins.
    always_comb begin
        srv_idx_d = srv_idx_q;
        srv_ext_d = srv_ext_q;
        if (take_sys) begin
            srv_ext_d = 1'b0;
        end else if (take_ext) begin
            srv_ext_d = 1'b1;
            srv_idx_d = win_idx;
        end
        clr    = (ack_fire && srv_ext_q) ? (NUM_SRC'(1) << srv_idx_q) : '0;
        pend_d = (pend_q & ~clr) | (irq & ~irq_prev_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q <= '0;
            pend_q     <= '0;
            srv_idx_q  <= '0;
            srv_ext_q  <= 1'b0;
        end else begin
            irq_prev_q <= irq;
            pend_q     <= pend_d;
            srv_idx_q  <= srv_idx_d;
            srv_ext_q  <= srv_ext_d;
        end
    end

    assign pending = pend_q;
`else
    assign pending = irq;
`endif

    assign int_req     = (state_q == ST_REQ);
    assign int_cause   = cause_q;
    assign int_enable  = ie_q;
    assign int_mask    = mask_q;
    assign int_pending = pending;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed scenarios then random traffic against a reference model.
module tb_int_arbiter;

    localparam int NUM  = 8;
    localparam int BASE = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NUM-1:0]  irq;
    logic            mask_we;
    logic [NUM-1:0]  mask_wdata;
    logic            syscall, eret, int_ack;
    logic            int_req;
    logic [31:0]     int_cause;
    logic            int_enable;
    logic [NUM-1:0]  int_mask, int_pending;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: 0 = idle, 1 = waiting for ack, 2 = handler running.
    int             m_state;
    bit             m_ie;
    logic [NUM-1:0] m_mask;
    logic [31:0]    m_cause;
    int             m_src;
`ifdef INT_EDGE_EN
    logic [NUM-1:0] m_pend, m_prev;
`endif

    int_arbiter #(.NUM_SRC(NUM), .EXT_CAUSE_BASE(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .syscall     (syscall),
        .eret        (eret),
        .int_ack     (int_ack),
        .int_req     (int_req),
        .int_cause   (int_cause),
        .int_enable  (int_enable),
        .int_mask    (int_mask),
        .int_pending (int_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM-1:0] model_pending();
`ifdef INT_EDGE_EN
        return m_pend;
`else
        return irq;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ie    = 1'b1;
        m_mask  = '1;
        m_cause = 0;
        m_src   = -1;
`ifdef INT_EDGE_EN
        m_pend  = '0;
        m_prev  = '0;
`endif
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_edge();
        logic [NUM-1:0] pend_now;
        logic [NUM-1:0] served;
        pend_now = model_pending();
        served   = '0;
        if (m_state == 0) begin
            if (syscall) begin
                m_state = 1; m_cause = 8; m_src = -1;
            end else if (m_ie && (pend_now & m_mask) != 0) begin
                for (int i = 0; i < NUM; i++) begin
                    if (pend_now[i] && m_mask[i]) begin m_src = i; break; end
                end
                m_cause = 32'(BASE + m_src);
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (int_ack) begin
                m_state = 2; m_ie = 1'b0;
                if (m_src >= 0) served[m_src] = 1'b1;
            end
        end else if (eret) begin
            m_state = 0; m_ie = 1'b1;
        end
        if (mask_we) m_mask = mask_wdata;
`ifdef INT_EDGE_EN
        m_pend = (m_pend & ~served) | (irq & ~m_prev);
        m_prev = irq;
`else
        if (served != 0) m_src = m_src;
`endif
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".req"},   32'(int_req),     32'(m_state == 1));
        check({tag, ".cause"}, int_cause,        m_cause);
        check({tag, ".ie"},    32'(int_enable),  32'(m_ie));
        check({tag, ".mask"},  32'(int_mask),    32'(m_mask));
        check({tag, ".pend"},  32'(int_pending), 32'(model_pending()));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !int_req; i++) tick(tag);
        check({tag, ".req_seen"}, 32'(int_req), 32'd1);
    endtask

    task automatic pulse_ack(input string tag);
        int_ack = 1'b1; tick(tag); int_ack = 1'b0;
    endtask

    task automatic pulse_eret(input string tag);
        eret = 1'b1; tick(tag); eret = 1'b0;
    endtask

    task automatic write_mask(input string tag, input logic [NUM-1:0] v);
        mask_we = 1'b1; mask_wdata = v; tick(tag); mask_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
        syscall = 1'b0; eret = 1'b0; int_ack = 1'b0;
        model_reset();
        #1;
        check("rst.req",   32'(int_req),     32'd0);
        check("rst.cause", int_cause,        32'd0);
        check("rst.ie",    32'(int_enable),  32'd1);
        check("rst.mask",  32'(int_mask),    32'hff);
        check("rst.pend",  32'(int_pending), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single source 3.
        irq = 8'h08;
        wait_req("s3", 4);
        check("s3.cause19", int_cause, 32'd19);
        pulse_ack("s3.ack");
        check("s3.ie_off", 32'(int_enable), 32'd0);
`ifdef INT_EDGE_EN
        check("s3.pend3_clr", 32'(int_pending[3]), 32'd0);
`endif
        irq = '0;
        pulse_eret("s3.eret");
        check("s3.ie_on", 32'(int_enable), 32'd1);

        // Sources 2 and 5 together: lowest first, then the other.
        irq = 8'h24;
        wait_req("s25a", 4);
        check("s25.cause18", int_cause, 32'd18);
        pulse_ack("s25a.ack");
        irq = 8'h20;
        pulse_eret("s25a.eret");
        wait_req("s25b", 4);
        check("s25.cause21", int_cause, 32'd21);
        pulse_ack("s25b.ack");
        irq = '0;
        pulse_eret("s25b.eret");

        // Syscall beats a pending (masked) source 0 and never clears it.
        write_mask("sc.mask0", 8'h00);
        irq = 8'h01;
        tick("sc.wait");
        tick("sc.wait");
        check("sc.pend0", 32'(int_pending[0]), 32'd1);
        syscall = 1'b1; tick("sc.take"); syscall = 1'b0;
        check("sc.cause8", int_cause, 32'd8);
        pulse_ack("sc.ack");
        check("sc.pend0_kept", 32'(int_pending[0]), 32'd1);
        check("sc.ie_off", 32'(int_enable), 32'd0);
        write_mask("sc.unmask", 8'hff);
        pulse_eret("sc.eret");
        wait_req("sc.s0", 4);
        check("sc.cause16", int_cause, 32'd16);
        pulse_ack("sc.s0.ack");
        irq = '0;
        pulse_eret("sc.s0.eret");

        // Masked source stays silent; the mask write itself still evaluates with the old mask.
        write_mask("mk.zero", 8'h00);
        irq = 8'h02;
        for (int i = 0; i < 4; i++) tick("mk.silent");
        check("mk.no_req", 32'(int_req), 32'd0);
        write_mask("mk.open", 8'h02);
        check("mk.old_mask", 32'(int_req), 32'd0);
        tick("mk.eval");
        check("mk.req", 32'(int_req), 32'd1);
        check("mk.cause17", int_cause, 32'd17);
        pulse_ack("mk.ack");
        irq = '0;
        pulse_eret("mk.eret");
        write_mask("mk.restore", 8'hff);

        // Stray eret/int_ack in idle do nothing.
        eret = 1'b1; int_ack = 1'b1; tick("idle.stray"); eret = 1'b0; int_ack = 1'b0;
        check("idle.req", 32'(int_req), 32'd0);
        check("idle.ie", 32'(int_enable), 32'd1);
        check("idle.cause", int_cause, 32'd17);
        tick("idle.hold");

        // Reset while a request is outstanding.
        syscall = 1'b1; tick("rr.take"); syscall = 1'b0;
        check("rr.req", 32'(int_req), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("rr.req0",   32'(int_req),    32'd0);
        check("rr.cause0", int_cause,       32'd0);
        check("rr.ie1",    32'(int_enable), 32'd1);
        check("rr.mask",   32'(int_mask),   32'hff);
        @(posedge clk); #1 reset = 1'b0;
        tick("rr.after");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            int k;
            if ($urandom_range(3) == 0) begin
                k = int'($urandom_range(NUM - 1));
                irq[k] = ~irq[k];
            end
            syscall    = ($urandom_range(7) == 0);
            int_ack    = ($urandom_range(2) == 0);
            eret       = ($urandom_range(3) == 0);
            mask_we    = ($urandom_range(15) == 0);
            mask_wdata = NUM'($urandom);
            tick("rand");
        end
        irq = '0; syscall = 1'b0; int_ack = 1'b0; eret = 1'b0; mask_we = 1'b0;
        tick("rand.end");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter: NUM_SRC, default 8, number of external interrupt sources (legal 1..16).
REQ-002 Parameter: EXT_CAUSE_BASE, default 16, cause code of source 0; source i reports EXT_CAUSE_BASE+i.
REQ-003 Port: clk  in  1  system clock; all state on rising edge.
REQ-004 Port: reset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 Port: irq  in  NUM_SRC  external interrupt lines, level, synchronous to clk.
REQ-006 Port: mask_we  in  1  write strobe for mask register.
REQ-007 Port: mask_wdata  in  NUM_SRC  new mask value, bit=1 enables source.
REQ-008 Port: syscall  in  1  one-cycle software exception request from control FSM.
REQ-009 Port: eret  in  1  one-cycle return-from-exception strobe from control FSM.
REQ-010 Port: int_ack  in  1  control FSM has taken the request (EPC written, PC redirected).
REQ-011 Port: int_req  out  1  exception/interrupt request to control FSM.
REQ-012 Port: int_cause  out  32  cause code of current request.
REQ-013 Port: int_enable  out  1  global interrupt enable (status IE).
REQ-014 Port: int_mask  out  NUM_SRC  current mask register.
REQ-015 Port: int_pending  out  NUM_SRC  current pending vector.

Function
REQ-016 FSM states IDLE, REQ, SERVICE; state is registered.
REQ-017 IDLE->REQ when syscall=1, or int_enable=1 and |(int_pending & int_mask)=1; evaluated with pre-edge mask.
REQ-018 Syscall has priority over external sources and is accepted even when int_enable=0; cause = 8.
REQ-019 Among external sources, lowest index wins; cause = EXT_CAUSE_BASE+index.
REQ-020 int_cause is latched on IDLE->REQ and held constant until next IDLE->REQ.
REQ-021 int_req = 1 exactly while in REQ (registered, one-cycle latency from triggering event).
REQ-022 REQ->SERVICE on int_ack; same edge clears int_enable; int_ack outside REQ is ignored.
REQ-023 SERVICE->IDLE on eret; same edge sets int_enable; eret outside SERVICE is ignored.
REQ-024 syscall in REQ or SERVICE is ignored (no nesting).
REQ-025 mask_we updates int_mask on the next edge in any state; takes effect for next IDLE evaluation.
REQ-026 Simultaneous mask_we and request evaluation: evaluation uses old mask.
REQ-027 int_pending bit clears only for the source served, on the int_ack edge (edge mode); never for syscall.

Reset
REQ-028 On reset: state IDLE, int_req 0, int_cause 0, int_enable 1, int_mask all ones, int_pending 0, edge-detect history 0.
REQ-029 Reset mid-REQ or mid-SERVICE abandons the request; no output retains pre-reset value.

Configuration
REQ-030 Macro INT_EDGE_EN defined: each pending bit sets on a 0->1 transition of irq[i], stays set until cleared per REQ-027; set wins over clear in same cycle.
REQ-031 INT_EDGE_EN undefined: int_pending = irq (combinational level), REQ-027 clearing absent; source must deassert irq in software.

Structure
REQ-032 Shared package int_pkg holds state enum, SYSCALL_CAUSE=8, default EXT_CAUSE_BASE, max NUM_SRC.
REQ-033 One sub-module prio_enc (parametrised lowest-index priority encoder, outputs index and valid); everything else in int_arbiter.

Verification
REQ-034 irq[3] pulse, mask all ones, IE=1 -> int_req next cycle, int_cause=19; int_ack -> SERVICE, int_enable=0, pending[3]=0.
REQ-035 irq[2] and irq[5] together -> cause 18; after eret, second request cause 21 (edge mode).
REQ-036 syscall with int_enable=0 and irq[0] pending -> cause 8; pending[0] remains 1.
REQ-037 mask_wdata=8'h00 then irq[1] -> no int_req; mask_wdata=8'h02 -> int_req with cause 17.
REQ-038 reset asserted while in REQ -> int_req=0, int_cause=0, int_enable=1 immediately, state IDLE.
REQ-039 eret in IDLE and int_ack in IDLE -> no state/output change.
